// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract accumulator and its adder core.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int CNT_W = 8;

endpackage : addsub_pkg

// File: rtl/addsub_core.sv
// Combinational W-bit two's complement add/subtract: s = x + (y ^ {W{sub}}) + sub,
// with the carry out of bit W-1 and the signed-overflow flag.
module addsub_core #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);

    logic [W-1:0] w_y_eff;
    logic [W:0]   w_sum;

    assign w_y_eff = y ^ {W{sub}};
    assign w_sum   = {1'b0, x} + {1'b0, w_y_eff} + {{W{1'b0}}, sub};

    assign s    = w_sum[W-1:0];
    assign cout = w_sum[W];
    // Overflow uses the effective operand so subtract is judged as x + ~y + 1.
    assign ovf  = (x[W-1] == w_y_eff[W-1]) && (w_sum[W-1] != x[W-1]);

endmodule : addsub_core

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator: IDLE -> EXEC -> DONE per command, result and flags registered.
// Optional build macro ADDSUB_SAT_EN clamps the accumulator on signed overflow.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             load,
    input  logic [W-1:0]     operand,
    output logic [W-1:0]     acc,
    output logic             carry,
    output logic             ovf,
    output logic             out_valid,
    output logic [CNT_W-1:0] op_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_exec;

    logic             r_op;
    logic             r_load;
    logic [W-1:0]     r_operand;

    logic [W-1:0]     r_acc;
    logic             r_carry;
    logic             r_ovf;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_op_count;

    logic [W-1:0]     w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [W-1:0]     w_acc_next;
    logic             w_carry_next;
    logic             w_ovf_next;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: defaults first, so no path through this block leaves a latch behind.
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC:    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign in_ready = (r_state == IDLE);
    assign w_exec   = (r_state == EXEC);

    // ------------------------------------------------------ command capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_ADD;
            r_load    <= 1'b0;
            r_operand <= '0;
        end else if (w_accept) begin
            r_op      <= op;
            r_load    <= load;
            r_operand <= operand;
        end
    end

    addsub_core #(
        .W (W)
    ) u_core (
        .x    (r_acc),
        .y    (r_operand),
        .sub  (r_op == OP_SUB),
        .s    (w_sum),
        .cout (w_cout),
        .ovf  (w_ovf)
    );

    // ------------------------------------------------------- result select
    always_comb begin
        w_acc_next   = w_sum;
        w_carry_next = w_cout;
        w_ovf_next   = w_ovf;
`ifdef ADDSUB_SAT_EN
        // Clamp toward the sign of x; the flags still describe the raw sum.
        if (w_ovf) begin
            w_acc_next = r_acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        if (r_load) begin
            w_acc_next   = r_operand;
            w_carry_next = 1'b0;
            w_ovf_next   = 1'b0;
        end
    end

    // ------------------------------------------ accumulator, flags, counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_out_valid <= w_exec;
            if (w_exec) begin
                r_acc      <= w_acc_next;
                r_carry    <= w_carry_next;
                r_ovf      <= w_ovf_next;
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign acc       = r_acc;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;
    assign op_count  = r_op_count;

endmodule : addsub_accumulator

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: directed test-plan cases plus random
// commands scored against an integer-arithmetic reference model.
module tb_addsub_accumulator;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       op;
    logic       load;
    logic [3:0] operand;
    logic [3:0] acc;
    logic       carry;
    logic       ovf;
    logic       out_valid;
    logic [7:0] op_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, kept as plain integers.
    int m_acc   = 0;
    int m_carry = 0;
    int m_ovf   = 0;
    int m_cnt   = 0;

    typedef struct packed {
        logic       sb;
        logic [3:0] y;
    } cmd_t;

    addsub_accumulator #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .load      (load),
        .operand   (operand),
        .acc       (acc),
        .carry     (carry),
        .ovf       (ovf),
        .out_valid (out_valid),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int to_signed4(input int u);
        return (u >= 8) ? u - 16 : u;
    endfunction

    function automatic void model_reset();
        m_acc   = 0;
        m_carry = 0;
        m_ovf   = 0;
        m_cnt   = 0;
    endfunction

    // Arithmetic meaning of a command: unsigned for carry/borrow, signed range for overflow.
    function automatic void model_apply(input logic ld, input logic sb, input logic [3:0] y);
        int ux   = m_acc;
        int uy   = int'(y);
        int sx   = to_signed4(ux);
        int sy   = to_signed4(uy);
        int res;
        int ssum;
        if (ld) begin
            m_acc   = uy;
            m_carry = 0;
            m_ovf   = 0;
        end else begin
            if (!sb) begin
                res     = (ux + uy) % 16;
                m_carry = (ux + uy >= 16) ? 1 : 0;
                ssum    = sx + sy;
            end else begin
                res     = (ux - uy + 16) % 16;
                m_carry = (ux >= uy) ? 1 : 0;
                ssum    = sx - sy;
            end
            m_ovf = (ssum > 7 || ssum < -8) ? 1 : 0;
`ifdef ADDSUB_SAT_EN
            if (m_ovf == 1) res = (sx < 0) ? 8 : 7;
`endif
            m_acc = res;
        end
        m_cnt = (m_cnt + 1) % 256;
    endfunction

    // Drives one command through accept, EXEC and DONE, checking each phase.
    task automatic run_cmd(input logic ld, input logic sb, input logic [3:0] y);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        load     = ld;
        op       = sb;
        operand  = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        load     = ~ld;
        op       = ~sb;
        operand  = 4'($urandom);
        model_apply(ld, sb, y);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL exec_phase: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL done_pulse: out_valid=%b required 1", out_valid);
        end
        n_vec++;
        if (acc !== 4'(m_acc) || carry !== 1'(m_carry) || ovf !== 1'(m_ovf)) begin
            n_err++;
            $display("FAIL result: acc=%b carry=%b ovf=%b required acc=%b carry=%0d ovf=%0d (ld=%b sb=%b y=%b)",
                     acc, carry, ovf, 4'(m_acc), m_carry, m_ovf, ld, sb, y);
        end
        n_vec++;
        if (op_count !== 8'(m_cnt)) begin
            n_err++;
            $display("FAIL op_count: got %0d required %0d", op_count, m_cnt);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL return_idle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 1'b0;
        load     = 1'b0;
        operand  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_vec++;
        if (acc !== 4'b0000 || carry !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0
            || op_count !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_values: acc=%b carry=%b ovf=%b out_valid=%b op_count=%0d in_ready=%b required 0000 0 0 0 0 1",
                     acc, carry, ovf, out_valid, op_count, in_ready);
        end
    endtask

    task automatic test_load_add();
        run_cmd(1'b1, 1'b0, 4'b0011);
        run_cmd(1'b0, 1'b0, 4'b0010);
        n_vec++;
        if (acc !== 4'b0101 || carry !== 1'b0 || ovf !== 1'b0 || op_count !== 8'd2) begin
            n_err++;
            $display("FAIL load_add: acc=%b carry=%b ovf=%b op_count=%0d required 0101 0 0 2",
                     acc, carry, ovf, op_count);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_a;
        logic [3:0] exp_b;
`ifdef ADDSUB_SAT_EN
        exp_a = 4'b1000;
        exp_b = 4'b0111;
`else
        exp_a = 4'b0110;
        exp_b = 4'b1000;
`endif
        run_cmd(1'b1, 1'b0, 4'b1011);
        run_cmd(1'b0, 1'b0, 4'b1011);
        n_vec++;
        if (acc !== exp_a || carry !== 1'b1 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_negative: acc=%b carry=%b ovf=%b required %b 1 1", acc, carry, ovf, exp_a);
        end
        run_cmd(1'b1, 1'b0, 4'b0111);
        run_cmd(1'b0, 1'b0, 4'b0001);
        n_vec++;
        if (acc !== exp_b || carry !== 1'b0 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_positive: acc=%b carry=%b ovf=%b required %b 0 1", acc, carry, ovf, exp_b);
        end
    endtask

    task automatic test_subtract();
        run_cmd(1'b1, 1'b0, 4'b0101);
        run_cmd(1'b0, 1'b1, 4'b0010);
        n_vec++;
        if (acc !== 4'b0011 || carry !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL sub_basic: acc=%b carry=%b ovf=%b required 0011 1 0", acc, carry, ovf);
        end
        run_cmd(1'b1, 1'b0, 4'b0100);
        run_cmd(1'b0, 1'b1, 4'b0100);
        n_vec++;
        if (acc !== 4'b0000 || carry !== 1'b1) begin
            n_err++;
            $display("FAIL sub_zero: acc=%b carry=%b required 0000 1", acc, carry);
        end
        run_cmd(1'b1, 1'b0, 4'b0001);
        run_cmd(1'b0, 1'b1, 4'b0010);
        n_vec++;
        if (acc !== 4'b1111 || carry !== 1'b0) begin
            n_err++;
            $display("FAIL sub_borrow: acc=%b carry=%b required 1111 0", acc, carry);
        end
    endtask

    task automatic test_back_to_back();
        int   accept_cyc[$];
        cmd_t pend[$];
        cmd_t cur;
        int   pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 9) begin
                in_valid = 1'b1;
                load     = 1'b0;
                op       = 1'($urandom);
                operand  = 4'($urandom);
                if (in_ready === 1'b1) begin
                    accept_cyc.push_back(c);
                    pend.push_back({op, operand});
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                pulses++;
                if (pend.size() > 0) begin
                    cur = pend.pop_front();
                    model_apply(1'b0, cur.sb, cur.y);
                end
                n_vec++;
                if (acc !== 4'(m_acc) || carry !== 1'(m_carry) || ovf !== 1'(m_ovf)) begin
                    n_err++;
                    $display("FAIL b2b_result: acc=%b carry=%b ovf=%b required %b %0d %0d",
                             acc, carry, ovf, 4'(m_acc), m_carry, m_ovf);
                end
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (accept_cyc.size() != 3) begin
            n_err++;
            $display("FAIL b2b_accepts: got %0d required 3", accept_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (accept_cyc[i] - accept_cyc[i-1] != 3) begin
                    n_err++;
                    $display("FAIL b2b_spacing: got %0d required 3", accept_cyc[i] - accept_cyc[i-1]);
                end
            end
        end
        n_vec++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d required 3", pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_cmd(($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom));
        end
    endtask

    task automatic test_reset_in_exec();
        run_cmd(1'b1, 1'b0, 4'b1001);
        in_valid = 1'b1;
        load     = 1'b0;
        op       = 1'b0;
        operand  = 4'b0011;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_accept: in_ready=%b required 0", in_ready);
        end
        rst     = 1'b1;
        operand = 4'($urandom);
        @(posedge clk); #1;
        model_reset();
        n_vec++;
        if (acc !== 4'b0000 || carry !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0
            || op_count !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_reset: acc=%b carry=%b ovf=%b out_valid=%b op_count=%0d in_ready=%b required 0000 0 0 0 0 1",
                     acc, carry, ovf, out_valid, op_count, in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dominates: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        rst     = 1'b0;
        load    = 1'b1;
        operand = 4'b0101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_apply(1'b1, 1'b0, 4'b0101);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_accept: in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b1 || acc !== 4'b0101 || op_count !== 8'd1) begin
            n_err++;
            $display("FAIL post_reset_result: out_valid=%b acc=%b op_count=%0d required 1 0101 1",
                     out_valid, acc, op_count);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_idle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_random();
        test_reset_in_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_addsub_accumulator
